muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations.
- Extends the multicycle datapath's ALU path: the controller issues an operation with a start pulse, stalls while busy is high, and captures the result on done.
- Operand width is generic (XLEN).
- Supports early completion for the special division cases and cancellation via flush.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit_if : request/response bundle for the iterative mul/div unit     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, flush, funct3, SrcA, SrcB,
    input  busy, done, Result
  );

  modport slave (
    input  start, flush, funct3, SrcA, SrcB,
    output busy, done, Result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit : iterative RV32M-style multiply (shift-add) / divide (restoring)|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  wire logic    CLK,
  input  wire logic    RESET,
  muldiv_unit_if.slave bus
);
  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_RUN      = 2'd1;
  localparam logic [1:0]       c_DONE     = 2'd2;
  localparam logic [XLEN-1:0]  c_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  // Operand decode at latch time
  logic            w_accept, w_sgn_a_en, w_sgn_b_en, w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;
  logic            w_div0, w_ovf, w_special;

  assign w_accept   = bus.start & ~bus.flush;
  assign w_sgn_a_en = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                      (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110);
  assign w_sgn_b_en = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) |
                      (bus.funct3 == 3'b110);
  assign w_sa       = w_sgn_a_en & bus.SrcA[XLEN-1];
  assign w_sb       = w_sgn_b_en & bus.SrcB[XLEN-1];
  assign w_mag_a    = w_sa ? (~bus.SrcA + 1'b1) : bus.SrcA;
  assign w_mag_b    = w_sb ? (~bus.SrcB + 1'b1) : bus.SrcB;
  assign w_div0     = bus.funct3[2] & (bus.SrcB == '0);
  assign w_ovf      = bus.funct3[2] & ~bus.funct3[0] &
                      (bus.SrcA == c_MIN) & (bus.SrcB == '1);
  assign w_special  = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = bus.funct3[1] ? bus.SrcA : '1;
    else
      w_special_res = bus.funct3[1] ? '0 : c_MIN;
  end

  // Single-iteration datapath: mul keeps {partial, multiplier}, div keeps {rem, quotient}
  logic [XLEN:0]     w_mul_sum, w_div_hi, w_div_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mul_nxt  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_hi   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_hi - {1'b0, r_b};
  assign w_div_nxt  = w_div_diff[XLEN] ? {w_div_hi[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt  = r_op[2] ? w_div_nxt : w_mul_nxt;

  assign w_prod = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quo  = r_neg_q ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_r ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    if (r_op[2])
      w_final = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00)
      w_final = w_prod[XLEN-1:0];
    else
      w_final = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r_state <= c_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = w_special ? c_DONE : c_RUN;
      c_RUN:   if (bus.flush) w_state_nxt = c_IDLE;
               else if (r_cnt == c_CNT_ONE) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (r_state == c_RUN);
    bus.done   = (r_state == c_DONE);
    bus.Result = r_result;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.funct3;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_b     <= bus.funct3[2] ? w_mag_b : w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_mag_a : w_mag_b)};
            if (w_special)
              r_result <= w_special_res;
            else
              r_cnt <= c_CNT_INIT;
          end
        end
        c_RUN: begin
          if (bus.flush) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
            r_acc <= w_acc_nxt;
            if (r_cnt == c_CNT_ONE)
              r_result <= w_final;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit : directed self-checking bench for muldiv_unit (XLEN=32)     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total  = 0;
  int   n_passed = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op; optionally present a competing start (SrcA=9) during cycle inj_cyc.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int inj_cyc);
    int lat;
    int nbusy;
    bus.funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) nbusy++;
      if (lat == inj_cyc) begin
        bus.start = 1'b1;
        bus.SrcA  = 32'd9;
      end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    chk({name, "_result"}, bus.Result, exp);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    chk({name, "_busy_with_done"}, {31'd0, bus.busy}, 32'd0);
    tick();
  endtask

  initial begin
    int ndone;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;

    tick();
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_result", bus.Result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mul_7_m3",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("div_m7_2",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,        33, 0);
    run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,         33, 0);

    run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
    run_op("rem_by0",     3'b110, 32'd5,        32'd0,        32'd5,         1, 0);
    run_op("div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

    run_op("mul_3_4_inj", 3'b000, 32'd3,        32'd4,        32'd12,        33, 5);

    // Flush mid-run: drop to IDLE, no done, Result keeps 12
    bus.funct3 = 3'b000;
    bus.SrcA   = 32'd5;
    bus.SrcB   = 32'd6;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result_kept", bus.Result, 32'd12);

    // Start together with flush in IDLE is dropped
    bus.funct3 = 3'b101;
    bus.SrcA   = 32'd5;
    bus.SrcB   = 32'd0;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_flush_done", {31'd0, bus.done}, 32'd0);
    tick();

    // Reset during DIVU 1000/3 at cycle 20
    bus.funct3 = 3'b101;
    bus.SrcA   = 32'd1000;
    bus.SrcB   = 32'd3;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.Result, 32'd0);
    tick();
    run_op("divu_1000_3", 3'b101, 32'd1000, 32'd3, 32'd333, 33, 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end
endmodule
`default_nettype wire
